// File: rtl/queue_sched.sv
// queue_sched: byte queue with DEPTH-entry shift storage.
// Two byte producers are arbitrated round-robin into the tail of the queue.
// One consumer pops one or two bytes from the head per transaction.
// Popped bytes are returned as a registered 2*W word, with the head byte in
// the upper half.
// Occupancy is tracked in a registered count. full/empty are decoded from
// that count, so they are glitch-free with respect to clk.

module queue_sched #(
  parameter int DEPTH = 5,
  parameter int W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   data0,
  output logic           gnt0,
  input  logic           req1,
  input  logic [W-1:0]   data1,
  output logic           gnt1,
  input  logic           pop_req,
  input  logic           pop_two,
  output logic           pop_ack,
  input  logic           flush,
  output logic [2*W-1:0] top_conc,
  output logic           out_valid,
  output logic [2:0]     count,
  output logic           full,
  output logic           empty
);

  localparam int CW = 3;

  // Storage: arr[0] is the head. Slots at or above count are kept at zero.
  logic [W-1:0]   arr     [DEPTH];
  // Storage extended by two zero slots, so a shift never reads past the end.
  logic [W-1:0]   arr_ext [DEPTH+2];
  logic [W-1:0]   arr_n   [DEPTH];

  logic [CW-1:0]  need;
  logic [CW-1:0]  popped;
  logic [CW-1:0]  wr_idx;
  logic [CW-1:0]  count_n;
  logic           rr_ptr;
  logic           push_ok;
  logic           push;
  logic [W-1:0]   push_data;
  logic [2*W-1:0] pop_word;

  // ---------------------------------------------------------------------
  // Request decode: pop acceptance and push arbitration (combinational)
  // ---------------------------------------------------------------------
  assign need    = pop_two ? CW'(2) : CW'(1);
  assign pop_ack = pop_req & ~flush & (count >= need);

  // A push never passes through a same-cycle pop. A full queue refuses
  // pushes even when it is draining on this edge.
  assign push_ok = ~flush & ~full;

  // With both requests active, rr_ptr picks the producer to grant.
  assign gnt0 = push_ok & req0 & (~req1 | ~rr_ptr);
  assign gnt1 = push_ok & req1 & (~req0 |  rr_ptr);

  assign push      = gnt0 | gnt1;
  assign push_data = gnt1 ? data1 : data0;

  // The tail index is computed after this cycle's shift, so a push lands
  // directly behind the surviving entries.
  assign popped  = pop_ack ? need : '0;
  assign wr_idx  = count - popped;
  assign count_n = wr_idx + CW'(push);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // The lower byte is zero for a single-byte pop.
  assign pop_word = {arr[0], (pop_two ? arr[1] : {W{1'b0}})};

  // Build the zero-extended view of storage used by the shifter
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      arr_ext[i] = arr[i];
    end
    arr_ext[DEPTH]   = '0;
    arr_ext[DEPTH+1] = '0;
  end

  // Next storage: shift the head down by the popped amount, then insert
  // the granted byte at the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (popped == CW'(2)) begin
        arr_n[i] = arr_ext[i+2];
      end else if (popped == CW'(1)) begin
        arr_n[i] = arr_ext[i+1];
      end else begin
        arr_n[i] = arr_ext[i];
      end
      if (push && (wr_idx == CW'(i))) begin
        arr_n[i] = push_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // State update: storage, occupancy, popped word, arbitration pointer
  // ---------------------------------------------------------------------
  // Async reset clears everything. Flush empties the queue but keeps
  // top_conc and rr_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        arr[i] <= '0;
      end
      count     <= '0;
      top_conc  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        arr[i] <= '0;
      end
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        arr[i] <= arr_n[i];
      end
      count     <= count_n;
      out_valid <= pop_ack;
      if (pop_ack) begin
        top_conc <= pop_word;
      end
      // After a grant to producer k, the pointer moves to the other producer.
      if (push) begin
        rr_ptr <= gnt0;
      end
    end
  end

endmodule

// File: tb/tb_queue_sched.sv
// tb_queue_sched: directed bench for queue_sched.
// The stimulus process queues the expected popped word for each accepted pop.
// An independent monitor compares that word against top_conc whenever
// out_valid is seen.

module tb_queue_sched;

  localparam int DEPTH = 5;
  localparam int W     = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [W-1:0]   data0, data1;
  logic           gnt0, gnt1;
  logic           pop_req, pop_two, pop_ack;
  logic           flush;
  logic [2*W-1:0] top_conc;
  logic           out_valid;
  logic [2:0]     count;
  logic           full, empty;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q [$];

  queue_sched #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .pop_req   (pop_req),
    .pop_two   (pop_two),
    .pop_ack   (pop_ack),
    .flush     (flush),
    .top_conc  (top_conc),
    .out_valid (out_valid),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid: got top_conc %0h expected no pulse", top_conc);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (top_conc !== e) begin
          n_err++;
          $display("FAIL top_conc: got %0h expected %0h", top_conc, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] fill [5];
    rst = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
    pop_req = 0; pop_two = 0; flush = 0;
    step(); step();
    rst = 1'b0;

    // Reset state and idle
    chk("rst_top_conc", top_conc, 16'h0000);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_out_valid", out_valid, 0);
    end

    // Producer 0 pushes 11,22,33; pop two, then pop one
    req0 = 1;
    data0 = 8'h11; #1 chk("p0_gnt_a", gnt0, 1); step();
    data0 = 8'h22; #1 chk("p0_gnt_b", gnt0, 1); step();
    data0 = 8'h33; #1 chk("p0_gnt_c", gnt0, 1); step();
    req0 = 0;
    chk("p0_count3", count, 3);
    pop_req = 1; pop_two = 1;
    #1 chk("pop2_ack", pop_ack, 1);
    exp_q.push_back(16'h1122);
    step();
    pop_req = 0;
    chk("pop2_count", count, 1);
    pop_req = 1; pop_two = 0;
    #1 chk("pop1_ack", pop_ack, 1);
    exp_q.push_back(16'h3300);
    step();
    pop_req = 0;
    chk("pop1_empty", empty, 1);
    chk("pop1_count", count, 0);
    step();

    // Round-robin fill from reset with both producers requesting
    do_reset();
    req0 = 1; req1 = 1; data0 = 8'hA0; data1 = 8'hB0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", gnt1, (i % 2 == 0) ? 0 : 1);
      step();
    end
    chk("rr_full", full, 1);
    chk("rr_count", count, 5);
    #1;
    chk("rr_full_gnt0", gnt0, 0);
    chk("rr_full_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    pop_req = 1; pop_two = 1;
    #1 chk("rr_pop_a", pop_ack, 1); exp_q.push_back(16'hA0B0); step();
    #1 chk("rr_pop_b", pop_ack, 1); exp_q.push_back(16'hA0B0); step();
    chk("rr_count1", count, 1);

    // count=1 with pop_two held: refused until a same-cycle push arrives
    req1 = 1; data1 = 8'hC1;
    #1;
    chk("hold_no_ack", pop_ack, 0);
    chk("hold_gnt1", gnt1, 1);
    step();
    req1 = 0;
    #1 chk("hold_ack", pop_ack, 1);
    exp_q.push_back(16'hA0C1);
    step();
    pop_req = 0;
    chk("hold_count0", count, 0);

    // Fill to full, then pop one together with a refused push
    fill[0] = 8'h01; fill[1] = 8'h02; fill[2] = 8'h03; fill[3] = 8'h04; fill[4] = 8'h05;
    req0 = 1;
    for (int i = 0; i < 5; i++) begin
      data0 = fill[i];
      step();
    end
    chk("fill_full", full, 1);
    data0 = 8'h55; pop_req = 1; pop_two = 0;
    #1;
    chk("fullpop_ack", pop_ack, 1);
    chk("fullpop_gnt0", gnt0, 0);
    exp_q.push_back(16'h0100);
    step();
    pop_req = 0;
    chk("fullpop_count4", count, 4);
    #1 chk("fullpop_gnt0_next", gnt0, 1);
    step();
    req0 = 0;
    chk("fullpop_count5", count, 5);
    // Back-to-back pops: 02 03 | 04 05 | 55
    pop_req = 1; pop_two = 1;
    #1 chk("b2b_ack_a", pop_ack, 1); exp_q.push_back(16'h0203); step();
    #1 chk("b2b_ack_b", pop_ack, 1); exp_q.push_back(16'h0405); step();
    pop_two = 0;
    #1 chk("b2b_ack_c", pop_ack, 1); exp_q.push_back(16'h5500); step();
    chk("b2b_out_valid", out_valid, 1);
    pop_req = 0;
    chk("b2b_empty", empty, 1);

    // Flush with a pop request and a push request in the same cycle
    req1 = 1;
    data1 = 8'h10; step();
    data1 = 8'h20; step();
    data1 = 8'h30; step();
    chk("fl_count3", count, 3);
    flush = 1; pop_req = 1; data1 = 8'h40;
    #1;
    chk("fl_no_ack", pop_ack, 0);
    chk("fl_no_gnt", gnt1, 0);
    step();
    flush = 0; pop_req = 0; req1 = 0;
    chk("fl_count0", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_top_hold", top_conc, 16'h5500);
    chk("fl_no_valid", out_valid, 0);

    // Async reset while a pop is being acked
    req0 = 1;
    data0 = 8'h99; step();
    data0 = 8'hAA; step();
    req0 = 0;
    pop_req = 1; pop_two = 1;
    #1 chk("rstpop_ack", pop_ack, 1);
    #1 rst = 1;
    #1;
    chk("rstpop_top", top_conc, 16'h0000);
    chk("rstpop_valid", out_valid, 0);
    chk("rstpop_count", count, 0);
    pop_req = 0; pop_two = 0;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstpop_quiet", out_valid, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/queue_sched.md
# queue_sched

Byte-queue controller with integrated 5-entry storage. It arbitrates two byte producers round-robin into the queue and serves one consumer that pops one or two bytes per transaction. Popped data is presented as a 16-bit concatenated word (head byte in the upper half). The block sits between the byte sources and the downstream 16-bit consumer, and replaces free-running shifting with occupancy-tracked, handshaked push/pop.

## Interface
- DEPTH, 5, number of byte entries (count width = 3 bits; DEPTH ≤ 7)
- W, 8, entry width in bits; output width is 2*W
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  producer 0 push request
- data0  in  W  producer 0 byte
- gnt0  out  1  producer 0 grant; the push occurs this cycle (combinational)
- req1  in  1  producer 1 push request
- data1  in  W  producer 1 byte
- gnt1  out  1  producer 1 grant; the push occurs this cycle (combinational)
- pop_req  in  1  consumer pop request
- pop_two  in  1  with pop_req: 1 = pop two bytes, 0 = pop one byte
- pop_ack  out  1  pop accepted this cycle (combinational)
- flush  in  1  synchronous clear of queue contents
- top_conc  out  2*W  registered popped word
- out_valid  out  1  one-cycle pulse; top_conc was updated on this edge
- count  out  3  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage arr[0..DEPTH-1]; arr[0] is the head. Slots at index ≥ count always hold 0.
- Pop:
  - need = pop_two ? 2 : 1.
  - pop_ack = pop_req & ~flush & (count ≥ need).
  - When acked, the queue shifts down by need, and the vacated top slots are zeroed.
  - top_conc ← {arr[0], pop_two ? arr[1] : 0}, and out_valid pulses.
  - An unacked request has no effect. The consumer holds pop_req and pop_two until ack.
- Push arbitration:
  - At most one push per cycle.
  - No grant when full or when flush is high. This holds even if a pop occurs in the same cycle; there is no pass-through.
  - If exactly one req is high, that producer is granted.
  - If both are high, the producer equal to rr_ptr is granted.
  - After any grant to producer k, rr_ptr ← ~k. With no grant, rr_ptr holds.
- Write index = count − (pop_ack ? need : 0), evaluated after the same-cycle shift.
- Next count = count + push − popped.
- Flush:
  - count ← 0 and all slots ← 0.
  - No grant and no ack that cycle.
  - top_conc and rr_ptr hold.
- Widths: count arithmetic is unsigned 3-bit and never wraps, because the guards prevent it.

## Timing
- Reset (async assert): arr all 0, count 0, top_conc 0, out_valid 0, rr_ptr 0. Consequently full=0 and empty=1.
- gnt0, gnt1 and pop_ack are combinational in the same cycle as the request. The state update happens on the next rising edge.
- Pop latency: top_conc and out_valid are valid 1 cycle after the ack cycle. Back-to-back pops give back-to-back out_valid pulses.
- Push latency: a byte pushed in cycle N is visible to a pop in cycle N+1. When empty, it is the head at N+1.
- Simultaneous push and pop with count ≥ need: both occur, and count changes by +1 − need.
- Reset mid-transaction: all state clears at once, and out_valid is dropped even if an ack was in flight.
- full, empty and count are decoded from registered count, so they are glitch-free relative to clk.

## Test plan
- Reset then idle: top_conc=0x0000, count=0, empty=1, and no out_valid for 10 cycles.
- Producer 0 pushes 0x11, 0x22, 0x33 on consecutive cycles; then pop_two → top_conc=0x1122 one cycle after ack, count=1. Then pop one → top_conc=0x3300, empty=1.
- req0 and req1 held high with data 0xA0/0xB0 from reset → grants alternate 0,1,0,1,0 and stop at count=5 (full=1). The queue holds A0,B0,A0,B0,A0. Further reqs get no grant.
- count=1 with pop_two held → no ack. A push in the same cycle makes count=2; pop_ack asserts the next cycle, giving top_conc={byte0, byte1}.
- count=5 (full), with simultaneous pop one and req0 (0x55) → pop acked, gnt0=0, count=4. Next cycle the push is granted, 0x55 lands at index 4, count=5.
- count=3, flush asserted together with pop_req and req1 → no ack, no grant, count=0, all slots 0. An asynchronous rst pulse mid-pop clears top_conc to 0x0000 immediately.
